// File: rtl/pcileech_pcie_tlp_tx_arb.sv
// Round-robin TLP transmit arbiter feeding the PCIe core s_axis_tx port.
// One grant per packet; output registered through a 1-entry skid buffer.
module pcileech_pcie_tlp_tx_arb #(
    parameter  int NUM_CH     = 4,
    parameter  int DW         = 64,
    localparam int KW         = DW / 8,
    parameter  int BUF_AV_MIN = 2
) (
    input  logic                 clk_pcie,
    input  logic                 rst_n,
    input  logic                 link_up,
    input  logic [5:0]           tx_buf_av,
    input  logic [NUM_CH*DW-1:0] s_tdata,
    input  logic [NUM_CH*KW-1:0] s_tkeep,
    input  logic [NUM_CH-1:0]    s_tlast,
    input  logic [NUM_CH-1:0]    s_tvalid,
    output logic [NUM_CH-1:0]    s_tready,
    output logic [DW-1:0]        m_axis_tx_tdata,
    output logic [KW-1:0]        m_axis_tx_tkeep,
    output logic                 m_axis_tx_tlast,
    output logic                 m_axis_tx_tvalid,
    input  logic                 m_axis_tx_tready,
    output logic                 busy,
    output logic [2:0]           cur_ch,
    output logic [15:0]          drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_FLUSH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_cur_ch;
    logic [2:0]      r_last_grant;
    logic [15:0]     r_drop_cnt;

    logic [DW-1:0]   r_m_data;
    logic [KW-1:0]   r_m_keep;
    logic            r_m_last;
    logic            r_m_valid;
    logic [DW-1:0]   r_sk_data;
    logic [KW-1:0]   r_sk_keep;
    logic            r_sk_last;
    logic            r_sk_valid;

    logic [7:0]      w_vld8;
    logic [3:0]      w_idx;
    logic [2:0]      w_gnt_ch;
    logic            w_gnt_found;
    logic            w_gnt;
    logic [DW-1:0]   w_in_data;
    logic [KW-1:0]   w_in_keep;
    logic            w_in_last;
    logic            w_in_valid;
    logic            w_acc;
    logic            w_fl_acc;
    logic            w_pkt_end;
    logic            w_drop;
    logic            w_m_free;
    logic [NUM_CH-1:0] w_rdy;

    assign w_vld8 = 8'(s_tvalid);

    // Search starts one past the last granted channel, wrapping at NUM_CH.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_ch    = '0;
        w_idx       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = {1'b0, r_last_grant} + 4'(i);
            if (w_idx >= 4'(NUM_CH)) begin
                w_idx = w_idx - 4'(NUM_CH);
            end
            if (!w_gnt_found && w_vld8[w_idx[2:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_ch    = w_idx[2:0];
            end
        end
    end

    always_comb begin
        w_in_data  = '0;
        w_in_keep  = '0;
        w_in_last  = 1'b0;
        w_in_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_cur_ch == 3'(c)) begin
                w_in_data  = s_tdata[c*DW +: DW];
                w_in_keep  = s_tkeep[c*KW +: KW];
                w_in_last  = s_tlast[c];
                w_in_valid = s_tvalid[c];
            end
        end
    end

    assign w_gnt = (r_state == S_IDLE) && link_up &&
                   (tx_buf_av >= 6'(BUF_AV_MIN)) && w_gnt_found;
    assign w_acc     = (r_state == S_XFER) && w_in_valid && !r_sk_valid;
    assign w_fl_acc  = (r_state == S_FLUSH) && w_in_valid;
    assign w_pkt_end = (w_acc || w_fl_acc) && w_in_last;
    assign w_drop    = w_pkt_end && ((r_state == S_FLUSH) || !link_up);
    assign w_m_free  = !r_m_valid || m_axis_tx_tready;

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_pkt_end) w_state_nxt = S_IDLE;
                else if (!link_up) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_pkt_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Ready never depends on m_axis_tx_tready: only on state and skid occupancy.
    always_comb begin
        w_rdy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_cur_ch == 3'(c)) begin
                w_rdy[c] = ((r_state == S_XFER) && !r_sk_valid) ||
                           (r_state == S_FLUSH);
            end
        end
    end

    assign s_tready = w_rdy;

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_ch     <= '0;
            r_last_grant <= 3'(NUM_CH - 1);
            r_drop_cnt   <= '0;
        end else begin
            if (w_gnt) r_cur_ch <= w_gnt_ch;
            if (w_pkt_end) r_last_grant <= r_cur_ch;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_m_last   <= 1'b0;
            r_m_valid  <= 1'b0;
            r_sk_data  <= '0;
            r_sk_keep  <= '0;
            r_sk_last  <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (!link_up) begin
            r_m_valid  <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (w_m_free) begin
            if (r_sk_valid) begin
                r_m_data   <= r_sk_data;
                r_m_keep   <= r_sk_keep;
                r_m_last   <= r_sk_last;
                r_m_valid  <= 1'b1;
                r_sk_valid <= 1'b0;
            end else if (w_acc) begin
                r_m_data  <= w_in_data;
                r_m_keep  <= w_in_keep;
                r_m_last  <= w_in_last;
                r_m_valid <= 1'b1;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_acc) begin
            r_sk_data  <= w_in_data;
            r_sk_keep  <= w_in_keep;
            r_sk_last  <= w_in_last;
            r_sk_valid <= 1'b1;
        end
    end

    assign m_axis_tx_tdata  = r_m_data;
    assign m_axis_tx_tkeep  = r_m_keep;
    assign m_axis_tx_tlast  = r_m_last;
    assign m_axis_tx_tvalid = r_m_valid;
    assign busy     = (r_state != S_IDLE) || r_m_valid || r_sk_valid;
    assign cur_ch   = r_cur_ch;
    assign drop_cnt = r_drop_cnt;

endmodule
